countdown_timer: RTL and testbench

//  Loadable down counter; the count-down partner of the game's up counter.

---
 rtl/countdown_timer.sv | 104 ++++++++++
 tb/tb_countdown_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down counter for the game round time limit.
// Counts down once per 'en' strobe while running and pulses 'done' on expiry.
// Optional build macro AUTO_RELOAD_EN: periodic mode. On expiry the counter
// reloads from the last loaded value and keeps running instead of stopping.
module countdown_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;

  // State, count, reload value and done pulse registers; reset clears everything.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic with priority load > stop > start > en.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (count_q != '0)) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = EXPIRED;
`endif
            end
          end
        end

        EXPIRED: begin
          count_d = '0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign zero  = (count_q == '0);
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus randomized traffic checked
// every cycle against a rule-based reference model of the countdown timer.
module tb_countdown_timer;

  localparam int WIDTH = 6;

  logic             clk;
  logic             clr_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             done;

  int tests_run;
  int tests_failed;

  // Reference model: remaining time, last loaded limit, and whether the
  // round is running or has run out.
  int m_remaining;
  int m_limit;
  bit m_running;
  bit m_timed_out;
  bit m_done;

  int done_pulses;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_remaining = 0;
    m_limit     = 0;
    m_running   = 1'b0;
    m_timed_out = 1'b0;
    m_done      = 1'b0;
  endtask

  // One clock edge of the timer's rules, applied to the inputs of this cycle.
  task automatic modelStep(input bit ld, input int lv, input bit st, input bit sp, input bit e);
    m_done = 1'b0;
    if (ld) begin
      m_remaining = lv;
      m_limit     = lv;
      m_running   = 1'b0;
      m_timed_out = 1'b0;
    end else if (m_running) begin
      if (sp) begin
        m_running = 1'b0;
      end else if (e) begin
        if (m_remaining == 1) begin
          m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
          m_remaining = m_limit;
`else
          m_remaining = 0;
          m_running   = 1'b0;
          m_timed_out = 1'b1;
`endif
        end else begin
          m_remaining = m_remaining - 1;
        end
      end
    end else if (!m_timed_out) begin
      if (st && m_remaining > 0) m_running = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("count", int'(count), m_remaining);
    checkOutput("busy",  int'(busy),  int'(m_running));
    checkOutput("zero",  int'(zero),  int'(m_remaining == 0));
    checkOutput("done",  int'(done),  int'(m_done));
  endtask

  // Drive one cycle of inputs away from the edge, clock it, then check.
  task automatic applyStimulus(input bit ld, input int lv, input bit st, input bit sp, input bit e);
    @(negedge clk);
    load     = ld;
    load_val = WIDTH'(lv);
    start    = st;
    stop     = sp;
    en       = e;
    @(posedge clk);
    modelStep(ld, lv, st, sp, e);
    #1;
    compareAll();
    if (done) done_pulses++;
  endtask

  initial begin
    int lat;
    bit seen;

    tests_run    = 0;
    tests_failed = 0;
    done_pulses  = 0;
    clr_n    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    stop     = 1'b0;
    en       = 1'b0;
    modelReset();

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    clr_n = 1'b1;

    // Asynchronous reset in the middle of a run at count 17
    applyStimulus(1, 20, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pre_rst_count", int'(count), 17);
    #1;
    clr_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 1);

    // One-shot run from 5 with en every cycle
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    done_pulses = 0;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("oneshot_pulses", done_pulses, 1);
    repeat (3) applyStimulus(0, 0, 1, 0, 1);

    // Sparse en with pause and resume
    applyStimulus(1, 10, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    done_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("after3", int'(count), 7);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("held", int'(count), 7);
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("sparse_pulses", done_pulses, 1);

    // load beats en and start in the same cycle; start from zero is ignored
    applyStimulus(1, 10, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("prio_pre", int'(count), 4);
    applyStimulus(1, 9, 1, 0, 1);
    checkOutput("prio_count", int'(count), 9);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("zero_start_busy", int'(busy), 0);

    // Boundaries: limit of 1 and the full-range limit
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lat1_done", int'(done), 1);

    applyStimulus(1, 63, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      lat++;
      if (done) seen = 1'b1;
    end
    checkOutput("lat63", seen ? lat : -1, 63);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("nowrap", int'(count) == 63 ? 1 : int'(zero), 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      bit st;
      bit sp;
      bit e;
      int lv;
      ld = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 20);
      sp = ($urandom_range(0, 99) < 5);
      e  = ($urandom_range(0, 99) < 60);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
      applyStimulus(ld, lv, st, sp, e);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        clr_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        clr_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
